shiftout_chain: RTL and testbench

//  Parametrised serial shift-register driver for daisy-chained 74HC595-class parts (VFD grid/segment drivers).

---
 rtl/shiftout_chain.sv | 97 +++++++++
 tb/tb_shiftout_chain.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftout_chain.sv
// shiftout_chain: multi-channel shift-out driver for daisy-chained 74HC595-class parts.
// Optional SHIFTOUT_PRELOAD_EN adds a one-frame holding buffer for back-to-back frames.
module shiftout_chain #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int SHIFT_FREQ = 1_000_000,
  parameter int DATA_WIDTH = 25,
  parameter int CHANNELS   = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                           ICE_CLK,
  input  logic                           RST_N,
  input  logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN,
  input  logic                           DATA_VALID,
  output logic                           DATA_READY,
  output logic                           SHIFT_CLOCK,
  output logic [CHANNELS-1:0]            SHIFT_DATA,
  output logic                           SHIFT_LATCH,
  output logic                           BUSY,
  output logic                           FRAME_DONE
);
  localparam int HALF = (CLK_FREQ / (2 * SHIFT_FREQ)) < 1 ? 1 : CLK_FREQ / (2 * SHIFT_FREQ);
  localparam int CW = $clog2(HALF + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] sr_q, sr_d, src;
  logic accept, load, tick, last;
`ifdef SHIFTOUT_PRELOAD_EN
  logic [CHANNELS*DATA_WIDTH-1:0] buf_q;
  logic full_q;
  assign DATA_READY = !full_q;
  assign accept = DATA_VALID && DATA_READY;
  assign src = buf_q;
  assign load = full_q && (state_q == IDLE || state_q == DONE);
  assign BUSY = state_q != IDLE || full_q;
  always_ff @(posedge ICE_CLK or negedge RST_N)
    if (!RST_N) begin
      buf_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (accept) buf_q <= DATA_IN;
      full_q <= accept || (full_q && !load);
    end
`else
  assign DATA_READY = state_q == IDLE;
  assign accept = DATA_VALID && DATA_READY;
  assign src = DATA_IN;
  assign load = accept;
  assign BUSY = state_q != IDLE;
`endif
  assign tick = div_q == CW'(HALF - 1);
  assign last = bit_q == BW'(DATA_WIDTH - 1);
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sr_d = sr_q;
    div_d = (state_q == IDLE || state_q == DONE || tick) ? '0 : div_q + CW'(1);
    case (state_q)
      IDLE, DONE: begin
        bit_d = '0;
        state_d = load ? SHIFT_LO : IDLE;
        if (load) sr_d = src;
      end
      SHIFT_LO: state_d = tick ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: if (tick) begin
        state_d = last ? LATCH : SHIFT_LO;
        bit_d = bit_q + BW'(1);
        // the final bit stays on the line through the latch phase
        if (!last)
          for (int c = 0; c < CHANNELS; c++)
            sr_d[c] = MSB_FIRST != 0 ? sr_q[c] << 1 : sr_q[c] >> 1;
      end
      LATCH: state_d = tick ? DONE : LATCH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ICE_CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      div_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
    end
  assign SHIFT_CLOCK = state_q == SHIFT_HI;
  assign SHIFT_LATCH = state_q == LATCH;
  assign FRAME_DONE = state_q == DONE;
  always_comb
    for (int c = 0; c < CHANNELS; c++)
      SHIFT_DATA[c] = MSB_FIRST != 0 ? sr_q[c][DATA_WIDTH-1] : sr_q[c][0];
endmodule

// File: tb/tb_shiftout_chain.sv
// tb_shiftout_chain: table-driven scoreboard bench for shiftout_chain (HALF=6, 8 bits, 2 channels),
// plus an LSB-first instance and a HALF=1 single-bit instance.
module tb_shiftout_chain;
`ifdef SHIFTOUT_PRELOAD_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int FRAME = 102 + LAT;
  localparam int PERIOD = 104 - LAT;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  ser1;
    logic [7:0]  ser0;
  } vec_t;

  logic clk = 0, rst_n = 0;
  logic [15:0] din = '0, din_l = '0;
  logic [0:0] din_f = '0;
  logic vld = 0, vld_l = 0, vld_f = 0;
  logic rdy, sc, sl, busy, done;
  logic [1:0] sd;
  logic rdy_l, sc_l, sl_l, busy_l, done_l;
  logic [1:0] sd_l;
  logic rdy_f, sc_f, sl_f, busy_f, done_f;
  logic [0:0] sd_f;

  int errors = 0, checks = 0, cyc = 0;
  int rises = 0, latches = 0, bit_idx = 0, last_rise = 0, lw = 0;
  logic p_sc = 0, p_sl = 0;
  logic [1:0] exp_q[$];
  int dq[$];
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shiftout_chain #(.CLK_FREQ(12_000_000), .SHIFT_FREQ(1_000_000), .DATA_WIDTH(8), .CHANNELS(2), .MSB_FIRST(1)) u_msb (
    .ICE_CLK(clk), .RST_N(rst_n), .DATA_IN(din), .DATA_VALID(vld), .DATA_READY(rdy),
    .SHIFT_CLOCK(sc), .SHIFT_DATA(sd), .SHIFT_LATCH(sl), .BUSY(busy), .FRAME_DONE(done));
  shiftout_chain #(.CLK_FREQ(12_000_000), .SHIFT_FREQ(1_000_000), .DATA_WIDTH(8), .CHANNELS(2), .MSB_FIRST(0)) u_lsb (
    .ICE_CLK(clk), .RST_N(rst_n), .DATA_IN(din_l), .DATA_VALID(vld_l), .DATA_READY(rdy_l),
    .SHIFT_CLOCK(sc_l), .SHIFT_DATA(sd_l), .SHIFT_LATCH(sl_l), .BUSY(busy_l), .FRAME_DONE(done_l));
  shiftout_chain #(.CLK_FREQ(12_000_000), .SHIFT_FREQ(6_000_000), .DATA_WIDTH(1), .CHANNELS(1), .MSB_FIRST(1)) u_fast (
    .ICE_CLK(clk), .RST_N(rst_n), .DATA_IN(din_f), .DATA_VALID(vld_f), .DATA_READY(rdy_f),
    .SHIFT_CLOCK(sc_f), .SHIFT_DATA(sd_f), .SHIFT_LATCH(sl_f), .BUSY(busy_f), .FRAME_DONE(done_f));

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input vec_t v);
    for (int i = 0; i < 8; i++) exp_q.push_back({v.ser1[7-i], v.ser0[7-i]});
  endtask

  task automatic send(input logic [15:0] d, input bit keep, output int acc);
    int n = 0;
    din = d;
    vld = 1;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(n < 2000), 1);
    acc = cyc + 1;
    @(negedge clk);
    if (!keep) vld = 0;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    check("done_wait", int'(n < 3000), 1);
    dc = cyc;
  endtask

  // scoreboard monitor: pops one expected bit pair per rising SHIFT_CLOCK
  always @(negedge clk) begin
    if (!rst_n) begin
      bit_idx <= 0;
      p_sc <= 0;
      p_sl <= 0;
    end else begin
      p_sc <= sc;
      p_sl <= sl;
      if (sc && !p_sc) begin
        rises <= rises + 1;
        bit_idx <= bit_idx + 1;
        last_rise <= cyc;
        check("bit_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("serial_bits", int'(sd), int'(exp_q.pop_front()));
        if (bit_idx > 0) check("edge_spacing", cyc - last_rise, 12);
      end
      if (sl && !p_sl) begin
        latches <= latches + 1;
        lw <= 1;
        check("latch_vs_clock", int'(sc), 0);
      end else if (sl) lw <= lw + 1;
      if (!sl && p_sl) check("latch_width", lw, 6);
      if (done) begin
        dq.push_back(cyc);
        bit_idx <= 0;
      end
    end
  end

  initial begin
    int acc, dc, a0, a1, a2, r0, l0, d0, n, got, lat;
    logic [7:0] s0, s1;
    logic p, pl;
    vecs[0] = '{16'hA53C, 8'hA5, 8'h3C};
    vecs[1] = '{16'hFF00, 8'hFF, 8'h00};
    vecs[2] = '{16'h0180, 8'h01, 8'h80};
    vecs[3] = '{16'h5AC3, 8'h5A, 8'hC3};
    vecs[4] = '{16'h8001, 8'h80, 8'h01};

    // reset with VALID held high
    din = vecs[0].din;
    vld = 1;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(rdy), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_sclk", int'(sc), 0);
    check("rst_latch", int'(sl), 0);
    check("rst_sdata", int'(sd), 0);
    check("rst_done", int'(done), 0);
    push(vecs[0]);
    rst_n = 1;
    acc = cyc + 1;
    @(negedge clk);
    vld = 0;
    check("busy_after_accept", int'(busy), 1);
    wait_done(dc);
    check("frame_len", dc - acc, FRAME);

    for (int i = 0; i < 5; i++) begin
      l0 = latches;
      push(vecs[i]);
      send(vecs[i].din, 0, acc);
      wait_done(dc);
      check("frame_len", dc - acc, FRAME);
      check("bits_consumed", exp_q.size(), 0);
      @(negedge clk);
      check("one_latch", latches - l0, 1);
    end

    // VALID held across three frames
    repeat (3) @(negedge clk);
    dq.delete();
    r0 = rises;
    l0 = latches;
    push(vecs[1]);
    send(vecs[1].din, 1, a0);
    push(vecs[2]);
    send(vecs[2].din, 1, a1);
    push(vecs[3]);
    send(vecs[3].din, 0, a2);
    n = 0;
    while (dq.size() < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("frames_done", dq.size(), 3);
    check("b2b_edges", rises - r0, 24);
    check("b2b_latches", latches - l0, 3);
    if (dq.size() >= 3) begin
      check("frame_period", dq[1] - dq[0], PERIOD);
      check("frame_period", dq[2] - dq[1], PERIOD);
`ifdef SHIFTOUT_PRELOAD_EN
      check("preload_reaccept", a1 - a0, 2);
      check("preload_frame_len", dq[0] - a0, FRAME);
`else
      check("idle_gap", a1 - dq[0], 2);
      check("idle_gap", a2 - dq[1], 2);
`endif
    end

    // reset mid-shift after the 4th rising edge
    r0 = rises;
    push(vecs[4]);
    send(vecs[4].din, 0, acc);
    n = 0;
    while (rises - r0 < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("sclk_before_abort", int'(sc), 1);
    l0 = latches;
    d0 = dq.size();
    #2 rst_n = 0;
    #1;
    check("abort_sclk", int'(sc), 0);
    check("abort_latch", int'(sl), 0);
    check("abort_busy", int'(busy), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("abort_no_latch", latches - l0, 0);
    check("abort_no_done", dq.size() - d0, 0);
    r0 = rises;
    push(vecs[0]);
    send(vecs[0].din, 0, acc);
    wait_done(dc);
    check("post_abort_len", dc - acc, FRAME);
    check("post_abort_edges", rises - r0, 8);
    check("bits_consumed", exp_q.size(), 0);

    // LSB-first: ch0=8'h01, ch1=8'h80
    din_l = 16'h8001;
    vld_l = 1;
    check("lsb_ready", int'(rdy_l), 1);
    @(negedge clk);
    vld_l = 0;
    got = 0;
    lat = 0;
    s0 = '0;
    s1 = '0;
    p = 0;
    pl = 0;
    n = 0;
    while (!done_l && n < 300) begin
      if (sc_l && !p && got < 8) begin
        s0[got] = sd_l[0];
        s1[got] = sd_l[1];
        got++;
      end
      if (sl_l && !pl) lat++;
      p = sc_l;
      pl = sl_l;
      @(negedge clk);
      n++;
    end
    check("lsb_edges", got, 8);
    check("lsb_ch0", int'(s0), 8'h01);
    check("lsb_ch1", int'(s1), 8'h80);
    check("lsb_latches", lat, 1);
    check("lsb_busy_at_done", int'(busy_l), 1);

    // HALF=1, DATA_WIDTH=1
    @(negedge clk);
    din_f = 1'b1;
    vld_f = 1;
    check("fast_ready", int'(rdy_f), 1);
    @(negedge clk);
    vld_f = 0;
    for (int k = 0; k <= 3 + LAT; k++) begin
      check("fast_sclk", int'(sc_f), int'(k == 1 + LAT));
      check("fast_latch", int'(sl_f), int'(k == 2 + LAT));
      check("fast_done", int'(done_f), int'(k == 3 + LAT));
      check("fast_busy", int'(busy_f), 1);
      if (k == 1 + LAT) check("fast_sdata", int'(sd_f), 1);
      @(negedge clk);
    end
    check("fast_idle", int'(busy_f), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
